// File: rtl/ysyx_23060201_rf_pkg.sv
// Shared constants and helpers for the NPC general-purpose register file.
// Optional read bypass: define YSYX_23060201_RF_BYPASS_EN.
package ysyx_23060201_rf_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int REG_ZERO  = 0;

    // Low bit of port `port` inside a packed bus of `width`-bit fields.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/ysyx_23060201_rf_scoreboard.sv
// Busy scoreboard: one pending bit per GPR plus a running busy count.
// Issue sets a bit, writeback clears it; set beats clear on the same edge.
module ysyx_23060201_rf_scoreboard
    import ysyx_23060201_rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NR_WR  = 2
) (
    input  logic                      gpr_clk,
    input  logic                      gpr_rst,
    input  logic [NR_WR-1:0]          sb_wen,
    input  logic [NR_WR*ADDR_W-1:0]   sb_waddr,
    input  logic                      sb_iss_valid,
    input  logic [ADDR_W-1:0]         sb_iss_rd,
    output logic [(1<<ADDR_W)-1:0]    sb_busy,
    output logic [ADDR_W:0]           sb_busy_cnt
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [ADDR_W-1:0] waddr_a [NR_WR];
    logic [NREG-1:0]   clr_v;
    logic [NREG-1:0]   set_v;
    logic [NREG-1:0]   busy_nxt;
    logic [ADDR_W:0]   up_n;
    logic [ADDR_W:0]   dn_n;
    logic [ADDR_W:0]   cnt_nxt;

    for (genvar j = 0; j < NR_WR; j++) begin : g_wa
        assign waddr_a[j] =
            sb_waddr[slice_lo(j, ADDR_W) +: ADDR_W];
    end

    // Build clear/set masks; x0 never participates.
    always_comb begin
        clr_v = '0;
        set_v = '0;
        for (int j = 0; j < NR_WR; j++) begin
            if (sb_wen[j] && waddr_a[j] != ZERO_IDX) begin
                clr_v[waddr_a[j]] = 1'b1;
            end
        end
        if (sb_iss_valid && sb_iss_rd != ZERO_IDX) begin
            set_v[sb_iss_rd] = 1'b1;
        end
    end

    // Next busy vector and incremental count from bit transitions.
    always_comb begin
        busy_nxt = (sb_busy & ~clr_v) | set_v;
        up_n     = '0;
        dn_n     = '0;
        for (int r = 0; r < NREG; r++) begin
            up_n = up_n + {{ADDR_W{1'b0}},
                           ~sb_busy[r] & busy_nxt[r]};
            dn_n = dn_n + {{ADDR_W{1'b0}},
                           sb_busy[r] & ~busy_nxt[r]};
        end
        cnt_nxt = sb_busy_cnt + up_n - dn_n;
    end

    // Busy bits and count register.
    always_ff @(posedge gpr_clk or posedge gpr_rst) begin
        if (gpr_rst) begin
            sb_busy     <= '0;
            sb_busy_cnt <= '0;
        end else begin
            sb_busy     <= busy_nxt;
            sb_busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/ysyx_23060201_regfile_sb.sv
// NPC GPR file: multi-port read/write, x0 hardwired, busy scoreboard.
// Define YSYX_23060201_RF_BYPASS_EN to forward same-cycle writes to reads.
module ysyx_23060201_regfile_sb
    import ysyx_23060201_rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W,
    parameter int NR_RD  = 2,
    parameter int NR_WR  = 2
) (
    input  logic                      rf_clk,
    input  logic                      rf_rst,
    input  logic [NR_RD-1:0]          rf_ren,
    input  logic [NR_RD*ADDR_W-1:0]   rf_raddr,
    output logic [NR_RD*DATA_W-1:0]   rf_rdata,
    output logic [NR_RD-1:0]          rf_rbusy,
    input  logic [NR_WR-1:0]          rf_wen,
    input  logic [NR_WR*ADDR_W-1:0]   rf_waddr,
    input  logic [NR_WR*DATA_W-1:0]   rf_wdata,
    input  logic                      rf_iss_valid,
    input  logic [ADDR_W-1:0]         rf_iss_rd,
    output logic [ADDR_W:0]           rf_busy_cnt
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] mem [NREG];
    logic [NREG-1:0]   busy_v;

    logic [ADDR_W-1:0] raddr_a [NR_RD];
    logic [ADDR_W-1:0] waddr_a [NR_WR];
    logic [DATA_W-1:0] wdata_a [NR_WR];
    logic [DATA_W-1:0] rdata_a [NR_RD];
    logic              rbusy_a [NR_RD];

    for (genvar i = 0; i < NR_RD; i++) begin : g_rd
        assign raddr_a[i] =
            rf_raddr[slice_lo(i, ADDR_W) +: ADDR_W];
        assign rf_rdata[slice_lo(i, DATA_W) +: DATA_W] = rdata_a[i];
        assign rf_rbusy[i] = rbusy_a[i];
    end

    for (genvar j = 0; j < NR_WR; j++) begin : g_wr
        assign waddr_a[j] =
            rf_waddr[slice_lo(j, ADDR_W) +: ADDR_W];
        assign wdata_a[j] =
            rf_wdata[slice_lo(j, DATA_W) +: DATA_W];
    end

    ysyx_23060201_rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NR_WR  (NR_WR)
    ) u_sb (
        .gpr_clk      (rf_clk),
        .gpr_rst      (rf_rst),
        .sb_wen       (rf_wen),
        .sb_waddr     (rf_waddr),
        .sb_iss_valid (rf_iss_valid),
        .sb_iss_rd    (rf_iss_rd),
        .sb_busy      (busy_v),
        .sb_busy_cnt  (rf_busy_cnt)
    );

    // Data array; later ports overwrite earlier ones on a shared address.
    always_ff @(posedge rf_clk or posedge rf_rst) begin
        if (rf_rst) begin
            for (int r = 0; r < NREG; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NR_WR; j++) begin
                if (rf_wen[j] && waddr_a[j] != ZERO_IDX) begin
                    mem[waddr_a[j]] <= wdata_a[j];
                end
            end
        end
    end

    // Combinational read muxing; outputs held at zero during reset.
    always_comb begin
        for (int i = 0; i < NR_RD; i++) begin
            rdata_a[i] = '0;
            rbusy_a[i] = 1'b0;
            if (!rf_rst && rf_ren[i] && raddr_a[i] != ZERO_IDX) begin
                rdata_a[i] = mem[raddr_a[i]];
                rbusy_a[i] = busy_v[raddr_a[i]];
`ifdef YSYX_23060201_RF_BYPASS_EN
                for (int j = 0; j < NR_WR; j++) begin
                    if (rf_wen[j] && waddr_a[j] == raddr_a[i]) begin
                        rdata_a[i] = wdata_a[j];
                        rbusy_a[i] = 1'b0;
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060201_regfile_sb.sv
// Self-checking bench for ysyx_23060201_regfile_sb against an array model.
// Honours YSYX_23060201_RF_BYPASS_EN for same-cycle read expectations.
module tb_ysyx_23060201_regfile_sb;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int NREG = 32;

    logic                rf_clk = 1'b0;
    logic                rf_rst;
    logic [NRD-1:0]      rf_ren;
    logic [NRD*AW-1:0]   rf_raddr;
    logic [NRD*DW-1:0]   rf_rdata;
    logic [NRD-1:0]      rf_rbusy;
    logic [NWR-1:0]      rf_wen;
    logic [NWR*AW-1:0]   rf_waddr;
    logic [NWR*DW-1:0]   rf_wdata;
    logic                rf_iss_valid;
    logic [AW-1:0]       rf_iss_rd;
    logic [AW:0]         rf_busy_cnt;

    logic [DW-1:0]       m_mem [NREG];
    logic [NREG-1:0]     m_busy;
    int                  total = 0;
    int                  bad = 0;

    always #5 rf_clk = ~rf_clk;

    ysyx_23060201_regfile_sb dut (
        .rf_clk       (rf_clk),
        .rf_rst       (rf_rst),
        .rf_ren       (rf_ren),
        .rf_raddr     (rf_raddr),
        .rf_rdata     (rf_rdata),
        .rf_rbusy     (rf_rbusy),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .rf_iss_valid (rf_iss_valid),
        .rf_iss_rd    (rf_iss_rd),
        .rf_busy_cnt  (rf_busy_cnt)
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) m_mem[r] = '0;
        m_busy = '0;
    endtask

    task automatic idle();
        rf_ren       = '0;
        rf_raddr     = '0;
        rf_wen       = '0;
        rf_waddr     = '0;
        rf_wdata     = '0;
        rf_iss_valid = 1'b0;
        rf_iss_rd    = '0;
    endtask

    task automatic set_rd(input int p, input int a);
        rf_ren[p] = 1'b1;
        rf_raddr[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int p, input int a,
                          input logic [DW-1:0] d);
        rf_wen[p] = 1'b1;
        rf_waddr[p*AW +: AW] = AW'(a);
        rf_wdata[p*DW +: DW] = d;
    endtask

    task automatic set_iss(input int a);
        rf_iss_valid = 1'b1;
        rf_iss_rd    = AW'(a);
    endtask

    // Expected read results follow the architectural rules directly.
    task automatic check_outputs(input string tag);
        for (int i = 0; i < NRD; i++) begin
            int a;
            logic [DW-1:0] ed;
            logic eb;
            a  = int'(rf_raddr[i*AW +: AW]);
            ed = '0;
            eb = 1'b0;
            if (!rf_rst && rf_ren[i] && a != 0) begin
                ed = m_mem[a];
                eb = m_busy[a];
`ifdef YSYX_23060201_RF_BYPASS_EN
                for (int j = 0; j < NWR; j++) begin
                    if (rf_wen[j] &&
                        int'(rf_waddr[j*AW +: AW]) == a) begin
                        ed = rf_wdata[j*DW +: DW];
                        eb = 1'b0;
                    end
                end
`endif
            end
            check({tag, "_rdata"}, rf_rdata[i*DW +: DW], ed);
            check({tag, "_rbusy"}, rf_rbusy[i], eb);
        end
        check({tag, "_cnt"}, rf_busy_cnt, $countones(m_busy));
    endtask

    task automatic model_edge();
        int a;
        if (rf_rst) return;
        for (int j = 0; j < NWR; j++) begin
            a = int'(rf_waddr[j*AW +: AW]);
            if (rf_wen[j] && a != 0) begin
                m_mem[a]  = rf_wdata[j*DW +: DW];
                m_busy[a] = 1'b0;
            end
        end
        if (rf_iss_valid && rf_iss_rd != 0) m_busy[rf_iss_rd] = 1'b1;
    endtask

    // Called at a negedge with inputs driven; ends at the next negedge.
    task automatic cycle(input string tag);
        #1 check_outputs(tag);
        @(posedge rf_clk);
        model_edge();
        @(negedge rf_clk);
    endtask

    initial begin
        int ord [31];
        int t;
        int k;

        rf_rst = 1'b1;
        idle();
        model_clear();
        @(negedge rf_clk);
        @(negedge rf_clk);
        set_rd(0, 5);
        cycle("reset");
        check("reset_cnt", rf_busy_cnt, 0);
        rf_rst = 1'b0;

        // Reset asserted in the middle of a write cycle.
        idle(); set_wr(0, 5, 32'h1111_2222); cycle("pre5");
        idle(); set_iss(5); cycle("iss5");
        idle(); set_rd(0, 5);
        #1 check("x5_busy_pre", rf_rbusy[0], 1);
        idle(); set_wr(0, 5, 32'hDEAD_BEEF); set_rd(0, 5);
        #2 rf_rst = 1'b1;
        model_clear();
        #1;
        check("rst_rdata", rf_rdata[DW-1:0], 0);
        check("rst_rbusy", rf_rbusy[0], 0);
        check("rst_cnt", rf_busy_cnt, 0);
        cycle("rst_mid");
        rf_rst = 1'b0;
        idle(); set_rd(0, 5);
        #1 check("post_rst_x5", rf_rdata[DW-1:0], 0);
        cycle("post_rst");

        // x0 protection.
        idle();
        set_wr(0, 0, 32'h1234); set_wr(1, 0, 32'h1234); set_iss(0);
        cycle("x0w");
        idle(); set_rd(0, 0); set_rd(1, 0);
        #1;
        check("x0_data", rf_rdata[DW-1:0], 0);
        check("x0_busy", rf_rbusy[0], 0);
        check("x0_cnt", rf_busy_cnt, 0);
        cycle("x0r");

        // Higher write port wins.
        idle(); set_wr(0, 3, 32'hAAAA); set_wr(1, 3, 32'h5555);
        cycle("prio_w");
        idle(); set_rd(1, 3);
        #1 check("prio_x3", rf_rdata[DW +: DW], 32'h5555);
        cycle("prio_r");

        // Scoreboard set / clear / set-beats-clear.
        idle(); set_iss(7); cycle("sb_iss");
        idle(); set_rd(0, 7);
        #1;
        check("sb_busy1", rf_rbusy[0], 1);
        check("sb_cnt1", rf_busy_cnt, 1);
        cycle("sb_r1");
        idle(); set_wr(1, 7, 32'h42); cycle("sb_wb");
        idle(); set_rd(0, 7);
        #1;
        check("sb_data42", rf_rdata[DW-1:0], 32'h42);
        check("sb_busy0", rf_rbusy[0], 0);
        check("sb_cnt0", rf_busy_cnt, 0);
        cycle("sb_r2");
        idle(); set_wr(0, 7, 32'h43); set_iss(7); cycle("sb_both");
        idle(); set_rd(0, 7);
        #1;
        check("sb_data43", rf_rdata[DW-1:0], 32'h43);
        check("sb_busy_set", rf_rbusy[0], 1);
        check("sb_cnt_set", rf_busy_cnt, 1);
        cycle("sb_r3");

        // Fill every register, then drain in shuffled pairs.
        for (int r = 1; r < NREG; r++) begin
            idle(); set_iss(r); set_rd(0, r); cycle("fill");
        end
        check("fill_cnt", rf_busy_cnt, 31);
        for (int r = 0; r < 31; r++) ord[r] = r + 1;
        for (int r = 30; r > 0; r--) begin
            k = int'($urandom_range(0, r));
            t = ord[r]; ord[r] = ord[k]; ord[k] = t;
        end
        for (int r = 0; r < 31; r += 2) begin
            idle();
            set_wr(0, ord[r], $urandom);
            if (r + 1 < 31) set_wr(1, ord[r+1], $urandom);
            set_rd(0, ord[r]);
            cycle("drain");
        end
        check("drain_cnt", rf_busy_cnt, 0);

        // Same-cycle read of a register being written.
        idle(); set_wr(0, 9, 32'h1111); set_iss(9); cycle("bp_pre");
        idle(); set_wr(1, 9, 32'hCAFE); set_rd(0, 9);
        #1;
`ifdef YSYX_23060201_RF_BYPASS_EN
        check("bp_same_data", rf_rdata[DW-1:0], 32'hCAFE);
        check("bp_same_busy", rf_rbusy[0], 0);
`else
        check("bp_same_data", rf_rdata[DW-1:0], 32'h1111);
        check("bp_same_busy", rf_rbusy[0], 1);
`endif
        cycle("bp_w");
        idle(); set_rd(0, 9);
        #1;
        check("bp_next_data", rf_rdata[DW-1:0], 32'hCAFE);
        check("bp_next_busy", rf_rbusy[0], 0);
        cycle("bp_r");

        // Random traffic with occasional asynchronous reset.
        for (int n = 0; n < 800; n++) begin
            idle();
            for (int i = 0; i < NRD; i++) begin
                if ($urandom_range(0, 3) != 0)
                    set_rd(i, int'($urandom_range(0, NREG - 1)));
            end
            for (int j = 0; j < NWR; j++) begin
                if ($urandom_range(0, 1) != 0) begin
                    if ($urandom_range(0, 1) != 0)
                        t = int'(rf_raddr[($urandom_range(0, 1))*AW +: AW]);
                    else
                        t = int'($urandom_range(0, NREG - 1));
                    set_wr(j, t, $urandom);
                end
            end
            if ($urandom_range(0, 2) != 0)
                set_iss(int'($urandom_range(0, NREG - 1)));
            if ($urandom_range(0, 99) == 0) begin
                #2 rf_rst = 1'b1;
                model_clear();
            end
            cycle("rnd");
            rf_rst = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
